// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: shares one registered adder among NUM_REQ requesters
// using round-robin arbitration, one outstanding operation at a time.
module adder_rr_scheduler #(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned DATA_W  = 8,
    parameter  int unsigned ADD_LAT = 1,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    output logic [DATA_W-1:0]         add_in1,
    output logic [DATA_W-1:0]         add_in2,
    input  logic [DATA_W:0]           add_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W:0]           rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy,
    output logic [15:0]               op_count
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    last_grant;
    logic [CNT_W-1:0]   cnt;

    logic               grant_vld;
    logic [ID_W-1:0]    grant;
    logic [DATA_W-1:0]  sel_in1;
    logic [DATA_W-1:0]  sel_in2;
    int unsigned        idx;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        sel_in1   = '0;
        sel_in2   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(last_grant) + 32'd1 + k) % NUM_REQ;
            if (!grant_vld && req_valid[ID_W'(idx)]) begin
                grant_vld = 1'b1;
                grant     = ID_W'(idx);
                sel_in1   = DATA_W'(req_in1 >> (idx * DATA_W));
                sel_in2   = DATA_W'(req_in2 >> (idx * DATA_W));
            end
        end
    end

    // Accept strobe is combinational, only in IDLE and never while in reset.
    always_comb begin
        req_ready = '0;
        if (!reset && state == ST_IDLE && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

    // Scheduler FSM: accept, wait out adder latency, hold response until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            cnt        <= '0;
            op_count   <= '0;
            add_in1    <= '0;
            add_in2    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        add_in1    <= sel_in1;
                        add_in2    <= sel_in2;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_W'(ADD_LAT);
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_data  <= add_out;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed self-checking bench for adder_rr_scheduler.
module tb_adder_rr_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADD_LAT = 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_in1;
    logic [NUM_REQ*DATA_W-1:0] req_in2;
    logic [DATA_W-1:0]         add_in1;
    logic [DATA_W-1:0]         add_in2;
    logic [DATA_W:0]           add_out;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W:0]           rsp_data;
    logic [1:0]                rsp_id;
    logic                      busy;
    logic [15:0]               op_count;

    int n_tests = 0;
    int n_fail  = 0;

    adder_rr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_out   (add_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Registered adder with one edge of latency.
    always @(posedge clk) begin
        add_out <= {1'b0, add_in1} + {1'b0, add_in2};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_in1[i*DATA_W +: DATA_W] = a;
        req_in2[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    int grants[6];
    int ng;
    int overlap_err;
    int pulse_err;
    int ghost;
    logic [NUM_REQ-1:0] prev_rdy;
    logic [8:0] hold_data;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        rsp_ready = 1'b0;

        // Single request; request already presented during reset.
        set_req(2, 8'd5, 8'd2);
        req_valid = 4'b0100;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        check("single_busy", 32'(busy), 32'd1);
        check("single_add_in1", 32'(add_in1), 32'd5);
        check("single_add_in2", 32'(add_in2), 32'd2);
        check("single_early", 32'(rsp_valid), 32'd0);
        tick();
        check("single_lat1", 32'(rsp_valid), 32'd0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'd1);
        check("single_data", 32'(rsp_data), 32'd7);
        check("single_id", 32'(rsp_id), 32'd2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("single_done", 32'(rsp_valid), 32'd0);
        check("single_opcnt", 32'(op_count), 32'd1);
        check("single_idle", 32'(busy), 32'd0);

        // Carry into the MSB.
        set_req(0, 8'd255, 8'd255);
        req_valid = 4'b0001;
        #1;
        check("carry_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        wait_rsp();
        check("carry_data", 32'(rsp_data), 32'h1FE);
        check("carry_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("carry_opcnt", 32'(op_count), 32'd2);

        // Fairness with all requesters valid and a free-running consumer.
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i), 8'd1);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        ng = 0;
        overlap_err = 0;
        pulse_err = 0;
        prev_rdy = '0;
        for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
            if ($countones(req_ready) > 1) overlap_err++;
            if ((prev_rdy != '0) && (req_ready != '0)) pulse_err++;
            if (req_ready != '0) begin
                for (int j = 0; j < 4; j++) if (req_ready[j]) grants[ng] = j;
                ng++;
            end
            prev_rdy = req_ready;
            tick();
        end
        req_valid = '0;
        check("fair_count", 32'(ng), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(i % 4));
        check("fair_onehot", 32'(overlap_err), 32'd0);
        check("fair_pulse", 32'(pulse_err), 32'd0);
        repeat (8) tick();
        check("fair_opcnt", 32'(op_count), 32'd6);

        // Backpressure: last grant was 1, so requester 2 is next.
        rsp_ready = 1'b0;
        set_req(2, 8'd10, 8'd20);
        req_valid = 4'b1111;
        #1;
        check("bp_ready", 32'(req_ready), 32'b0100);
        tick();
        wait_rsp();
        hold_data = rsp_data;
        check("bp_data", 32'(hold_data), 32'd30);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'(hold_data));
            check("bp_id", 32'(rsp_id), 32'd2);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        check("bp_done", 32'(rsp_valid), 32'd0);
        check("bp_opcnt", 32'(op_count), 32'd7);

        // Reset while waiting on the adder.
        set_req(0, 8'd1, 8'd1);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_busy_clr", 32'(busy), 32'd0);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_opcnt", 32'(op_count), 32'd0);
        check("mid_add_in1", 32'(add_in1), 32'd0);
        check("mid_add_in2", 32'(add_in2), 32'd0);
        reset = 1'b0;
        ghost = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid) ghost++;
        end
        check("mid_no_ghost", 32'(ghost), 32'd0);
        req_valid = 4'b1001;
        #1;
        check("mid_req0_wins", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_rsp();
        tick();
        rsp_ready = 1'b0;

        // Operand stability during WAIT and skipping a dropped requester.
        do_reset();
        set_req(0, 8'h12, 8'h34);
        set_req(1, 8'h01, 8'h01);
        set_req(2, 8'h40, 8'h02);
        req_valid = 4'b0011;
        #1;
        check("stab_ready", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 8'hAA, 8'hBB);
        req_valid = 4'b0110;
        rsp_ready = 1'b1;
        #1;
        check("stab_in1_a", 32'(add_in1), 32'h12);
        check("stab_in2_a", 32'(add_in2), 32'h34);
        req_valid = 4'b0100;
        tick();
        check("stab_in1_b", 32'(add_in1), 32'h12);
        check("stab_in2_b", 32'(add_in2), 32'h34);
        tick();
        check("stab_valid", 32'(rsp_valid), 32'd1);
        check("stab_data", 32'(rsp_data), 32'h46);
        check("stab_id", 32'(rsp_id), 32'd0);
        tick();
        check("skip_idle", 32'(busy), 32'd0);
        check("skip_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        wait_rsp();
        check("skip_data", 32'(rsp_data), 32'h42);
        check("skip_id", 32'(rsp_id), 32'd2);
        tick();
        check("skip_opcnt", 32'(op_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Shares one registered adder (clk, reset, in1, in2 -> out, DATA_W+1 bits wide) among NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- Round-robin arbitration picks one requester at a time. The block drives the adder's operands, waits the adder latency, then returns the sum with the requester's index on a valid/ready response channel.
- The block sits between the requesting blocks and the adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, operand width. The sum is DATA_W+1 bits.
- ADD_LAT, 1, adder latency in clock edges from stable inputs to valid out (0..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept. At most one bit is high.
- req_in1  input  NUM_REQ*DATA_W  packed first operands. Requester i uses bits [i*DATA_W +: DATA_W].
- req_in2  input  NUM_REQ*DATA_W  packed second operands, same packing.
- add_in1  output  DATA_W  to adder in1.
- add_in2  output  DATA_W  to adder in2.
- add_out  input  DATA_W+1  from adder out.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  DATA_W+1  sum, carry included.
- rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
- busy  output  1  high whenever state != IDLE.
- op_count  output  16  number of completed response handshakes. Wraps 0xFFFF -> 0.

Behaviour:
- Reset is synchronous and active-high. While reset is high at a clk edge:
  - state = IDLE, last_grant = NUM_REQ-1, cnt = 0, op_count = 0.
  - add_in1 = add_in2 = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - req_ready = 0 is forced during any cycle in which reset is high.
  - Reset mid-operation drops the in-flight operation silently. No response is ever produced for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - grant = first index with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[grant] is driven combinationally in the same cycle, and only in IDLE.
  - On the edge where req_valid[g] and req_ready[g] are both high:
    - latch that requester's in1/in2 into add_in1/add_in2;
    - set rsp_id = g and last_grant = g;
    - cnt = ADD_LAT; state -> WAIT.
  - With no req_valid, stay in IDLE. last_grant is unchanged.
- WAIT:
  - add_in1/add_in2 hold stable regardless of any requester input changes.
  - When cnt != 0, cnt decrements at each edge.
  - When cnt == 0, add_out is sampled into rsp_data at that edge, rsp_valid becomes 1, and state -> RESP.
  - Accept edge to first rsp_valid cycle = ADD_LAT+1 edges (2 for the default).
- RESP:
  - rsp_valid, rsp_data and rsp_id hold stable until rsp_ready is high.
  - On the edge with rsp_valid and rsp_ready both high: rsp_valid -> 0, op_count++, state -> IDLE.
  - If rsp_ready is already high on entry, the handshake completes in the first RESP cycle.
- No new request is accepted before the return to IDLE. Single outstanding operation.
- Minimum cycles per operation = ADD_LAT+3.
- Arithmetic: no truncation. rsp_data is exactly the DATA_W+1-bit adder output; the carry is in the MSB.
- A requester may drop req_valid before it is granted. It is then simply skipped; no error.
- An ungranted requester keeps its req_valid high and waits. Round-robin guarantees service within NUM_REQ operations.
- req_ready never depends on rsp_ready. There is no combinational path from rsp_ready to req_ready.

Test Plan:
- Single request. Reset 2 cycles, then req_valid[2]=1, in1=5, in2=2.
  - Required: req_ready[2] high in that cycle.
  - rsp_valid high 2 edges after the accept edge, with rsp_data=7, rsp_id=2.
  - After the response handshake, op_count=1.
- Carry. Requester 0 sends in1=255, in2=255.
  - Required: rsp_data=9'h1FE (510). The MSB must be set.
- Fairness. After reset, all four req_valid held high with rsp_ready=1.
  - Required: grants occur in order 0,1,2,3,0,1.
  - Each req_ready pulse lasts exactly one cycle. No two req_ready bits are ever high together.
- Backpressure. Hold rsp_ready=0 for 5 cycles while in RESP, with other requesters valid.
  - Required: rsp_valid, rsp_data and rsp_id stay constant; busy=1; all req_ready=0.
  - Completion occurs in the cycle rsp_ready rises.
- Reset mid-WAIT. Assert reset while in WAIT.
  - Required: on the next cycle busy=0, rsp_valid=0, op_count=0, add_in1=add_in2=0.
  - No response ever appears for the dropped operation.
  - With req 0 and req 3 both valid afterwards, req 0 wins.
- Operand stability and dropped request.
  - Change req_in1/req_in2 of the granted requester during WAIT. Required: add_in1/add_in2 stay unchanged.
  - Deassert req_valid[1] before its turn. Required: requester 1 is skipped without stall.
